dmem_mmio: RTL and testbench
============================

Name: dmem_mmio

Overview:
Data-memory responder for the single-cycle MIPS core's dmem side. It accepts the core's address, write data and write enable, and returns read data in the same cycle. It combines a word-addressed data RAM with a small memory-mapped I/O page. The I/O page holds an output byte FIFO drained by an external consumer (valid/ready), a free-running cycle counter, and sticky error flags.

Parameters:
RAM_WORDS, 256, number of 32-bit RAM words (power of 2)
FIFO_DEPTH, 8, output FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
mem_write  input  1  write strobe from core, sampled at posedge clk
addr  input  32  byte address from core ALU result
wdata  input  32  store data from core
rdata  output  32  load data, combinational from addr and current state
out_data  output  8  FIFO head byte
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head byte this cycle

Behaviour:
- Reset and clock: rst is synchronous, active-low; clk is the clock. Reset applies at a posedge with rst=0.
- State cleared by reset:
  - FIFO empty, so out_valid=0 and out_data=0.
  - CYCLES=0.
  - OVF=0, MIS=0.
- RAM contents are not reset.
- Address map (word-aligned):
  - 0x0000_0000..RAM_WORDS*4-1: RAM, index addr[log2(RAM_WORDS)+1:2].
  - 0xFFFF_0000 TXDATA: write pushes wdata[7:0]; read returns 0.
  - 0xFFFF_0004 STATUS: read returns {28'b0, OVF, MIS, full, empty}.
    - Write with wdata[3]=1 clears OVF.
    - Write with wdata[2]=1 clears MIS.
  - 0xFFFF_0008 CYCLES: read returns counter. Write loads wdata.
  - 0xFFFF_000C COUNT: read returns FIFO occupancy, zero-extended. Write ignored.
  - Any other address: read returns 0, write ignored. RAM addresses at or above RAM_WORDS*4 are unmapped.
- Reads:
  - Purely combinational, zero latency, as required by the single-cycle core.
  - addr[1:0] are ignored on reads.
  - A read in the same cycle as a write to the same location returns the old value. The write takes effect at the edge.
- Writes:
  - Take effect at posedge when mem_write=1 and rst=1.
  - If addr[1:0]!=0: write is discarded and MIS is set.
- FIFO:
  - Circular buffer with read/write pointers and occupancy counter.
  - out_valid = (count!=0).
  - out_data = head entry, or 0 when empty.
  - Pop at the edge when out_valid && out_ready.
  - Push at the edge on a TXDATA write.
  - Push when full and no simultaneous pop: byte dropped, OVF set, contents unchanged.
  - Push when full with simultaneous pop: both accepted, count stays FIFO_DEPTH.
  - Push when empty: out_valid rises the next cycle. No same-cycle bypass.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_data and out_valid must stay stable while out_valid=1 and out_ready=0.
- CYCLES:
  - Increments by 1 every cycle out of reset, wrapping 0xFFFF_FFFF->0.
  - A write has priority: next value = wdata, no increment that cycle.
- Sticky flags:
  - Set has priority over a clear in the same cycle.
  - A misaligned write to STATUS sets MIS and does not clear.
- Reset mid-operation: FIFO is flushed and queued bytes are lost. out_valid=0 after the reset edge regardless of out_ready.

Test Plan:
1. RAM round trip: write 0xDEADBEEF to 0x10, then 0x12345678 to 0x14 -> reads of 0x10/0x14 return those values. A same-cycle read of 0x10 during its write returns the prior value.
2. FIFO order/backpressure: hold out_ready=0 and push 0x41,0x42,0x43 -> COUNT=3 and out_data=0x41 stable. Raise out_ready -> 0x41,0x42,0x43 on consecutive cycles, then out_valid=0 and STATUS=0x1.
3. Overflow: push 9 bytes with out_ready=0 -> COUNT=8, STATUS=0xA. Drain -> bytes 1..8 appear, the 9th never does. Write 0x8 to STATUS -> OVF=0.
4. Full with simultaneous push+pop: fill to 8, push 0x55 while out_ready=1 -> COUNT stays 8, OVF=0, 0x55 emerges last.
5. Counter: after reset, read CYCLES at cycle N -> N. Write 0xFFFF_FFFE -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0 on the next three cycles.
6. Misaligned write to 0x11 plus reset mid-drain:
   - Misaligned write to 0x11 -> RAM word 0x10 unchanged and MIS=1.
   - Assert rst=0 with 4 bytes queued -> out_valid=0, COUNT=0, CYCLES=0, STATUS=0x1 after the edge.

Source files
------------

// File: rtl/dmem_mmio.sv
// Data-memory responder for the single-cycle MIPS core.
// Word-addressed RAM plus a small I/O page at 0xFFFF_0000: an output byte
// FIFO (valid/ready drain), a free-running cycle counter and sticky error
// flags. Reads are combinational; writes land at the clock edge.
module dmem_mmio #(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic [31:0]   cycles;
    logic          ovf;
    logic          mis;

    logic          aligned;
    logic          ram_hit;
    logic          io_hit;
    logic [AW-1:0] ram_idx;
    logic          wr_ok;
    logic          ram_we;
    logic          tx_we;
    logic          status_we;
    logic          cyc_we;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_ok;
    logic          ovf_set;
    logic          mis_set;
    logic          ovf_clr;
    logic          mis_clr;

    // Address decode and write qualification (a misaligned store is dropped)
    always_comb begin
        aligned   = (addr[1:0] == 2'b00);
        ram_hit   = (addr[31:AW+2] == '0);
        io_hit    = (addr[31:4] == 28'hFFFF000);
        ram_idx   = addr[AW+1:2];
        wr_ok     = rst && mem_write && aligned;
        ram_we    = wr_ok && ram_hit;
        tx_we     = wr_ok && io_hit && (addr[3:2] == 2'd0);
        status_we = wr_ok && io_hit && (addr[3:2] == 2'd1);
        cyc_we    = wr_ok && io_hit && (addr[3:2] == 2'd2);
        full      = (count == CW'(FIFO_DEPTH));
        empty     = (count == '0);
        pop       = !empty && out_ready;
        // A push into a full FIFO only fits if the head leaves on the same edge
        push_ok   = tx_we && (!full || pop);
        ovf_set   = tx_we && full && !pop;
        mis_set   = rst && mem_write && !aligned;
        ovf_clr   = status_we && wdata[3];
        mis_clr   = status_we && wdata[2];
    end

    // RAM store port; contents are deliberately left uninitialised by reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= wdata;
        end
    end

    // FIFO storage write; only the pointers/occupancy are reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wptr] <= wdata[7:0];
        end
    end

    // Control state: FIFO pointers, occupancy, cycle counter, sticky flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            cycles <= '0;
            ovf    <= 1'b0;
            mis    <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            cycles <= cyc_we ? wdata : cycles + 32'd1;
            // Set wins over a same-cycle clear
            ovf    <= ovf_set | (ovf & ~ovf_clr);
            mis    <= mis_set | (mis & ~mis_clr);
        end
    end

    // Stream outputs: head byte is held stable until it is accepted
    always_comb begin
        out_valid = !empty;
        out_data  = empty ? 8'h00 : fifo_mem[rptr];
    end

    // Combinational load path; byte offset bits are ignored on reads
    always_comb begin
        rdata = 32'h0;
        if (ram_hit) begin
            rdata = ram[ram_idx];
        end else if (io_hit) begin
            case (addr[3:2])
                2'd1:    rdata = {28'h0, ovf, mis, full, empty};
                2'd2:    rdata = cycles;
                2'd3:    rdata = {{(32-CW){1'b0}}, count};
                default: rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed stimulus, register reads checked inline,
// FIFO output stream checked by a scoreboard queue and a monitor process.
module tb_dmem_mmio;

    localparam logic [31:0] TXDATA = 32'hFFFF_0000;
    localparam logic [31:0] STATUS = 32'hFFFF_0004;
    localparam logic [31:0] CYCLES = 32'hFFFF_0008;
    localparam logic [31:0] COUNT  = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    dmem_mmio #(.RAM_WORDS(256), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_write = 1'b1;
        addr      = a;
        wdata     = d;
        tick();
        mem_write = 1'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(nm, rdata, exp);
    endtask

    task automatic push(input logic [7:0] b, input bit keep);
        if (keep) exp_q.push_back(b);
        wr(TXDATA, {24'h0, b});
    endtask

    // Monitor: every accepted byte must match the next expected byte
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stream_extra: got %h expected none", out_data);
            end else begin
                chk("stream", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b1;
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_data", {24'h0, out_data}, 32'h0);
        rd("rst_status", STATUS, 32'h1);
        rd("rst_count", COUNT, 32'h0);
        rd("rst_cycles", CYCLES, 32'h0);

        // Counter
        repeat (5) tick();
        rd("cyc_n5", CYCLES, 32'd5);
        wr(CYCLES, 32'hFFFF_FFFE);
        rd("cyc_load", CYCLES, 32'hFFFF_FFFE);
        tick();
        rd("cyc_max", CYCLES, 32'hFFFF_FFFF);
        tick();
        rd("cyc_wrap", CYCLES, 32'h0);

        // RAM round trip with read-during-write
        wr(32'h10, 32'h1111_1111);
        mem_write = 1'b1;
        addr      = 32'h10;
        wdata     = 32'hDEAD_BEEF;
        #1;
        chk("ram_rdw_old", rdata, 32'h1111_1111);
        tick();
        mem_write = 1'b0;
        wr(32'h14, 32'h1234_5678);
        rd("ram_10", 32'h10, 32'hDEAD_BEEF);
        rd("ram_14", 32'h14, 32'h1234_5678);
        rd("ram_13_ignores_lsb", 32'h13, 32'hDEAD_BEEF);
        rd("unmapped", 32'h400, 32'h0);

        // FIFO order and backpressure
        mem_write = 1'b1;
        addr      = TXDATA;
        wdata     = 32'h41;
        exp_q.push_back(8'h41);
        #1;
        chk("no_bypass", {31'h0, out_valid}, 32'h0);
        tick();
        mem_write = 1'b0;
        chk("valid_next", {31'h0, out_valid}, 32'h1);
        push(8'h42, 1'b1);
        push(8'h43, 1'b1);
        rd("fifo_count3", COUNT, 32'd3);
        rd("txdata_rd0", TXDATA, 32'h0);
        chk("head_hold0", {24'h0, out_data}, 32'h41);
        tick();
        chk("head_hold1", {24'h0, out_data}, 32'h41);
        chk("valid_hold", {31'h0, out_valid}, 32'h1);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        chk("drained_valid", {31'h0, out_valid}, 32'h0);
        rd("drained_status", STATUS, 32'h1);

        // Overflow
        for (int i = 1; i <= 9; i++) push(8'(i), i <= 8);
        rd("ovf_count", COUNT, 32'd8);
        rd("ovf_status", STATUS, 32'hA);
        out_ready = 1'b1;
        repeat (8) tick();
        out_ready = 1'b0;
        chk("ovf_drained", {31'h0, out_valid}, 32'h0);
        rd("ovf_sticky", STATUS, 32'h9);
        wr(STATUS, 32'h8);
        rd("ovf_cleared", STATUS, 32'h1);

        // Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) push(8'h60 + 8'(i), 1'b1);
        rd("full_count", COUNT, 32'd8);
        out_ready = 1'b1;
        mem_write = 1'b1;
        addr      = TXDATA;
        wdata     = 32'h55;
        exp_q.push_back(8'h55);
        tick();
        mem_write = 1'b0;
        out_ready = 1'b0;
        rd("pp_count", COUNT, 32'd8);
        rd("pp_status", STATUS, 32'h2);
        out_ready = 1'b1;
        repeat (8) tick();
        out_ready = 1'b0;
        chk("pp_drained", {31'h0, out_valid}, 32'h0);

        // Misaligned write, then reset mid-drain
        wr(32'h11, 32'h0000_0BAD);
        rd("mis_ram", 32'h10, 32'hDEAD_BEEF);
        rd("mis_status", STATUS, 32'h5);
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), 1'b0);
        rd("pre_rst_count", COUNT, 32'd4);
        out_ready = 1'b1;
        rst       = 1'b0;
        tick();
        rst = 1'b1;
        chk("rst2_valid", {31'h0, out_valid}, 32'h0);
        rd("rst2_count", COUNT, 32'h0);
        rd("rst2_cycles", CYCLES, 32'h0);
        rd("rst2_status", STATUS, 32'h1);
        out_ready = 1'b0;
        tick();

        chk("queue_empty", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
